// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 101 sequence detector.
// Ports: clk, rst (sync, active-low), data_in/load_valid/load_ready (word
// handshake), ser_out/ser_valid/last_bit (serial stream), busy (status).
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, busy_q;

    logic             accept;
    logic             end_word;
    logic [WIDTH-1:0] shifted;

    // Ready drops while in reset so loads offered then are ignored.
    assign load_ready = rst & ((state_q == IDLE) | ~hold_full_q);
    assign accept     = load_valid & load_ready;
    assign end_word   = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // Zero fill: after WIDTH shifts the register is all zeros, so idle
    // cycles naturally present 0 on ser_out.
    assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shifted;
                cnt_d   = cnt_q + CW'(1);
                if (end_word) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        // Bypass the hold register to keep the stream gapless.
                        shift_d = data_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    hold_d      = data_in;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            last_q      <= (state_d == SHIFT) && (cnt_d == CNT_LAST);
            busy_q      <= (state_d == SHIFT) || hold_full_d;
        end
    end

    assign ser_out   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign ser_valid = (state_q == SHIFT);
    assign last_bit  = last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first and LSB-first instances.
// Expected streams, ready and last patterns are hand-computed constants.
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in, data_in1;
    logic       load_valid, load_valid1;
    logic       load_ready, ser_out, ser_valid, last_bit, busy;
    logic       load_ready1, ser_out1, ser_valid1, last_bit1, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .last_bit  (last_bit),
        .busy      (busy)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in1),
        .load_valid(load_valid1),
        .load_ready(load_ready1),
        .ser_out   (ser_out1),
        .ser_valid (ser_valid1),
        .last_bit  (last_bit1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, ser_valid, 1'b0);
        check({tag, " bit"}, ser_out, 1'b0);
        check({tag, " last"}, last_bit, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " ready"}, load_ready, 1'b1);
    endtask

    task automatic accept(input logic [7:0] d);
        check("accept ready", load_ready, 1'b1);
        data_in    = d;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    // Runs n shifting cycles; bits/lr/lst are MSB-first over cycles 1..n.
    // Up to two words are offered at cycles o1/o2 and held until accepted.
    task automatic run(input string name, input int n,
                       input logic [31:0] bits, input logic [31:0] lr,
                       input logic [31:0] lst,
                       input int o1, input logic [7:0] d1,
                       input int o2, input logic [7:0] d2);
        logic acc;
        for (int c = 1; c <= n; c++) begin
            check($sformatf("%s c%0d valid", name, c), ser_valid, 1'b1);
            check($sformatf("%s c%0d bit", name, c), ser_out, bits[n-c]);
            check($sformatf("%s c%0d ready", name, c), load_ready, lr[n-c]);
            check($sformatf("%s c%0d last", name, c), last_bit, lst[n-c]);
            check($sformatf("%s c%0d busy", name, c), busy, 1'b1);
            if (c == o1) begin
                data_in    = d1;
                load_valid = 1'b1;
            end
            if (c == o2) begin
                data_in    = d2;
                load_valid = 1'b1;
            end
            acc = load_valid && load_ready;
            step();
            if (acc) load_valid = 1'b0;
        end
        check_idle({name, " end"});
    endtask

    initial begin
        logic h0, h1, s;
        logic [7:0] w;
        rst         = 1'b0;
        data_in     = 8'h00;
        load_valid  = 1'b0;
        data_in1    = 8'h00;
        load_valid1 = 1'b0;
        step();
        step();

        check("rst valid", ser_valid, 1'b0);
        check("rst bit", ser_out, 1'b0);
        check("rst last", last_bit, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst ready", load_ready, 1'b0);
        rst = 1'b1;
        #1;
        check_idle("post rst");

        // Single word.
        accept(8'hA5);
        run("single", 8, 32'hA5, 32'hFF, 32'h01, 0, 8'h00, 0, 8'h00);

        // Back-to-back through the hold register.
        accept(8'hA5);
        run("b2b", 16, 32'hA53C, 32'hC0FF, 32'h0101, 2, 8'h3C, 0, 8'h00);

        // Accept on the last bit with the hold empty.
        accept(8'hA5);
        run("simul", 16, 32'hA5FF, 32'hFFFF, 32'h0101, 8, 8'hFF, 0, 8'h00);

        // Backpressure: 8'h81 waits until the hold drains.
        accept(8'hA5);
        run("bp", 24, 32'hA53C81, 32'hC080FF, 32'h010101,
            2, 8'h3C, 3, 8'h81);

        // Reset mid-word with a held word.
        accept(8'hA5);
        w = 8'hA5;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("rstmid c%0d bit", c), ser_out, w[8-c]);
            if (c == 2) begin
                data_in    = 8'h3C;
                load_valid = 1'b1;
            end
            if (c == 3) load_valid = 1'b0;
            if (c == 4) begin
                rst        = 1'b0;
                data_in    = 8'h81;
                load_valid = 1'b1;
            end
            step();
        end
        for (int c = 5; c <= 6; c++) begin
            check($sformatf("rstmid c%0d valid", c), ser_valid, 1'b0);
            check($sformatf("rstmid c%0d busy", c), busy, 1'b0);
            check($sformatf("rstmid c%0d bit", c), ser_out, 1'b0);
            check($sformatf("rstmid c%0d ready", c), load_ready, 1'b0);
            step();
        end
        rst        = 1'b1;
        load_valid = 1'b0;
        #1;
        check_idle("rel");
        step();
        check_idle("no resume");
        accept(8'h05);
        run("after rst", 8, 32'h05, 32'hFF, 32'h01, 0, 8'h00, 0, 8'h00);

        // LSB-first instance into a bench-side 101 detector.
        h0 = 1'b0;
        h1 = 1'b0;
        check("lsb ready", load_ready1, 1'b1);
        data_in1    = 8'h05;
        load_valid1 = 1'b1;
        step();
        load_valid1 = 1'b0;
        w = 8'h05;
        for (int c = 1; c <= 8; c++) begin
            s = ser_out1;
            check($sformatf("lsb c%0d valid", c), ser_valid1, 1'b1);
            check($sformatf("lsb c%0d bit", c), s, w[c-1]);
            check($sformatf("lsb c%0d last", c), last_bit1, c == 8);
            check($sformatf("lsb c%0d det", c), h1 & ~h0 & s, c == 3);
            h1 = h0;
            h0 = s;
            step();
        end
        check("lsb end valid", ser_valid1, 1'b0);
        check("lsb end bit", ser_out1, 1'b0);
        check("lsb end busy", busy1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the 101 sequence-detector stage.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on ser_out, which drives the detector's in_seq input.
- A one-entry holding register gives gapless back-to-back words, so detector overlap across word boundaries is exercised exactly as the stream dictates.

Parameters:
- WIDTH, 8, word length in bits; legal range is 2 or more.
- MSB_FIRST, 1, bit order: 1 sends data_in[WIDTH-1] first, 0 sends data_in[0] first.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- data_in  input  WIDTH  parallel word to serialize.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit stream; connects to detector in_seq.
- ser_valid  output  1  ser_out carries a real data bit this cycle.
- last_bit  output  1  high during the cycle that carries the final bit of a word.
- busy  output  1  state is SHIFT or the hold register is full.

Behaviour:
- Handshake: a word is accepted at a rising edge where load_valid and load_ready are both 1. data_in is sampled only at that edge.
- Reset (rst=0 at an edge): state=IDLE, shift reg=0, hold reg=0, hold_full=0, bit_cnt=0.
  - Outputs after reset: ser_out=0, ser_valid=0, last_bit=0, busy=0.
  - load_ready=0 while rst is low; loads presented during reset are dropped.
  - Reset mid-word aborts the word. Nothing is resumed, including any held word.
- States: IDLE and SHIFT. bit_cnt is $clog2(WIDTH) bits wide and counts 0..WIDTH-1.
- IDLE:
  - load_ready=1 (when rst=1); ser_out=0, ser_valid=0.
  - On accept: shift reg<=data_in, bit_cnt<=0, go to SHIFT.
  - First bit appears in the cycle after the accepting edge (latency 1).
- SHIFT:
  - ser_valid=1.
  - ser_out is the shift-reg MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0). Every output is driven straight from registers.
  - Each edge: shift one position, fill with 0, bit_cnt+1.
  - load_ready = ~hold_full. An accept in SHIFT writes the hold reg and sets hold_full.
  - last_bit = (bit_cnt==WIDTH-1).
- At the edge ending the last bit:
  - hold_full=1: shift reg<=hold, hold_full<=0, bit_cnt<=0, stay in SHIFT. No idle cycle.
  - hold_full=0 and a simultaneous accept: data_in goes directly to the shift reg, bit_cnt<=0, stay in SHIFT. No gap.
  - Neither: go to IDLE. Next cycle ser_valid=0 and ser_out=0.
- Gaps drive 0 on ser_out. The detector sees idle zeros as data; a word ending in "10" followed by an idle 0 does not form 101, but a next word starting with 1 after the gap can.
- No word is ever dropped or duplicated while rst=1.
- ser_valid is high for exactly WIDTH cycles per accepted word.

Test Plan:
- WIDTH=8, MSB_FIRST=1, accept 8'hA5 at edge 0 -> ser_out over cycles 1..8 = 1,0,1,0,0,1,0,1; ser_valid=1 in cycles 1..8; last_bit=1 only in cycle 8; cycle 9 ser_valid=0, ser_out=0, load_ready=1.
- Back-to-back: accept 8'hA5, then 8'h3C in cycle 2 (goes to hold) -> 16 contiguous valid cycles: 10100101 then 00111100; last_bit in cycles 8 and 16; load_ready=0 in cycles 3..8.
- Simultaneous end/accept: hold empty, load_valid=1 with 8'hFF in cycle 8 of a word -> cycle 9 starts 1s immediately; no ser_valid gap.
- Backpressure: with the hold full, hold load_valid=1 with 8'h81 -> no accept until load_ready rises; 8'h81 is later serialized exactly once.
- Reset mid-word: rst=0 at edge 4 of 8'hA5 with a held word -> next cycle ser_valid=0, busy=0, ser_out=0; after release, the next accepted 8'h05 serializes cleanly.
- MSB_FIRST=0, 8'h05 chained into the 101 detector -> stream 1,0,1,0,0,0,0,0; detector out=1 in the cycle of the third bit, 0 elsewhere.
